// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Multiplies by shift-add and divides by restoring radix-2 division, one bit per
// cycle on operand magnitudes. Signs are re-applied when the result is captured.
// Divide-by-zero and signed overflow complete on the cycle after acceptance.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] tag_out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         op_q;
   logic [TAG_W-1:0]   tag_q;
   logic               neg_a_q;
   logic               neg_b_q;
   logic [WIDTH-1:0]   a_mag_q;
   logic [WIDTH-1:0]   b_mag_q;
   logic [2*WIDTH-1:0] acc_q;

   // Two's-complement negate of a WIDTH-bit value when n is set
   function automatic logic [WIDTH-1:0] cond_neg_w(input logic signed [WIDTH-1:0] v,
                                                   input logic n);
      cond_neg_w = n ? WIDTH'(-v) : WIDTH'(v);
   endfunction

   // Two's-complement negate of a full double-width product when n is set
   function automatic logic [2*WIDTH-1:0] cond_neg_p(input logic signed [2*WIDTH-1:0] v,
                                                     input logic n);
      cond_neg_p = n ? (2*WIDTH)'(-v) : (2*WIDTH)'(v);
   endfunction

   logic               accept;
   logic               sign_a;
   logic               sign_b;
   logic               div_zero;
   logic               div_ovf;
   logic               fast_path;
   logic [WIDTH-1:0]   fast_res;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   mul_res;
   logic [WIDTH-1:0]   div_res;

   assign accept    = start & ~flush & ((state == IDLE) | (state == DONE));
   assign sign_a    = op_a[WIDTH-1] & (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
   assign sign_b    = op_b[WIDTH-1] & (funct3 inside {3'd1, 3'd4, 3'd6});
   assign a_mag     = cond_neg_w(op_a, sign_a);
   assign b_mag     = cond_neg_w(op_b, sign_b);
   assign div_zero  = funct3[2] & (op_b == '0);
   assign div_ovf   = funct3[2] & ~funct3[0] & (op_a == MOST_NEG) & (&op_b);
   assign fast_path = div_zero | div_ovf;
   // Divide-by-zero wins over overflow; REM/REMU select the remainder column
   assign fast_res  = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MOST_NEG);

   // Multiply step: conditionally add the multiplicand into the high half, shift right
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide step: high half is the partial remainder, low half shifts dividend out / quotient in
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_mag_q};
   assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

   // Final results are formed from the last step's output so DONE follows the last iteration
   assign prod_signed = cond_neg_p(mul_next, neg_a_q ^ neg_b_q);
   assign mul_res     = (op_q == 2'd0) ? prod_signed[WIDTH-1:0] : prod_signed[2*WIDTH-1:WIDTH];
   assign div_res     = op_q[1] ? cond_neg_w(div_next[2*WIDTH-1:WIDTH], neg_a_q)
                                : cond_neg_w(div_next[WIDTH-1:0], neg_a_q ^ neg_b_q);

   // Operand capture on acceptance, then one shift-add or restoring step per cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= funct3[1:0];
         tag_q   <= tag_in;
         neg_a_q <= sign_a;
         neg_b_q <= sign_b;
         a_mag_q <= a_mag;
         b_mag_q <= b_mag;
         acc_q   <= funct3[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      end else if (state == MUL) begin
         acc_q <= mul_next;
      end else if (state == DIV) begin
         acc_q <= div_next;
      end
   end

   // Control FSM: state, iteration count and the registered busy/done/result/tag outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         tag_out <= '0;
      end else if (flush) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  cnt <= '0;
                  if (fast_path) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     result  <= fast_res;
                     tag_out <= tag_in;
                  end else begin
                     state <= funct3[2] ? DIV : MUL;
                     busy  <= 1'b1;
                  end
               end
            end
            MUL, DIV: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  tag_out <= tag_q;
                  result  <= (state == MUL) ? mul_res : div_res;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; legal values are even and at least 8.
REQ-002 SHALL have parameter TAG_W, default 5: width of the destination-register tag carried with each operation.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  operation request, sampled on the clock edge.
REQ-006 SHALL have port funct3  input  3  M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port op_a  input  WIDTH  rs1 operand (multiplicand or dividend).
REQ-008 SHALL have port op_b  input  WIDTH  rs2 operand (multiplier or divisor).
REQ-009 SHALL have port tag_in  input  TAG_W  destination tag.
REQ-010 SHALL have port flush  input  1  abort the in-flight operation.
REQ-011 SHALL have port busy  output  1  operation in progress; used as the pipeline stall request.
REQ-012 SHALL have port done  output  1  one-cycle pulse while result is valid.
REQ-013 SHALL have port result  output  WIDTH  operation result.
REQ-014 SHALL have port tag_out  output  TAG_W  tag of the completed operation.

Function
REQ-015 SHALL implement an FSM with states IDLE, MUL, DIV and DONE.
REQ-016 SHALL accept start in IDLE or DONE; start SHALL be ignored in MUL or DIV.
REQ-017 On acceptance, SHALL latch funct3, tag_in and the operand magnitudes, plus the sign flags for signed ops (MULH: both operands; MULHSU: op_a only; DIV/REM: both).
REQ-018 funct3 0-3 SHALL enter MUL; funct3 4-7 SHALL enter DIV unless the fast path of REQ-022 applies.
REQ-019 MUL SHALL run an iterative shift-add over a 2*WIDTH product for exactly WIDTH cycles, then enter DONE.
REQ-020 DIV SHALL run a restoring radix-2 divide, one quotient bit per cycle, for exactly WIDTH cycles, then enter DONE.
REQ-021 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL clear on every accepted start.
REQ-022 Fast path: a divisor of zero, or signed overflow (op_a equal to the most-negative value, op_b equal to all-ones, DIV/REM only), SHALL go directly to DONE on the next edge.
REQ-023 Divide by zero SHALL give quotient all-ones for both DIV and DIVU; the remainder SHALL equal op_a for both REM and REMU.
REQ-024 Signed overflow SHALL give DIV equal to the most-negative value and REM equal to 0.
REQ-025 Signs SHALL be applied on the transition to DONE:
- product negated if the sign flags differ;
- quotient negated if the sign flags differ;
- remainder takes the sign of the dividend.
REQ-026 MUL SHALL return the low WIDTH product bits; MULH, MULHSU and MULHU SHALL return the high WIDTH bits.
REQ-027 busy SHALL be 1 exactly in MUL and DIV; done SHALL be 1 exactly in DONE.
REQ-028 For iterative ops, done SHALL assert on cycle WIDTH+1 after the accepting edge.
REQ-029 For fast-path ops, done SHALL assert on cycle 1 after the accepting edge.
REQ-030 DONE SHALL last one cycle: without start it returns to IDLE; with start it accepts the new op (back-to-back).
REQ-031 result and tag_out SHALL hold their last value until the next DONE.
REQ-032 flush SHALL force IDLE on the next edge from any state, with no done pulse; flush with start in the same cycle SHALL be a flush and the start is discarded.

Reset
REQ-033 While rst is 0, the block SHALL hold: state IDLE, busy 0, done 0, result 0, tag_out 0, counter 0.
REQ-034 Reset asserted mid-operation SHALL abort immediately, with no done pulse after release.
REQ-035 After rst deasserts, the first start SHALL be accepted on the next clock edge.

Verification (WIDTH=32)
REQ-036 MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, done on cycle 33, busy high on cycles 1-32.
REQ-037 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU of the same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-038 DIVU 100/7 -> 14 and REMU -> 2; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each with done on cycle 33.
REQ-039 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each with done on cycle 1 and busy never asserted.
REQ-040 MUL started, flush on cycle 10 -> IDLE on cycle 11, no done; a start on cycle 11 completes with the correct result and tag.
REQ-041 Back-to-back: start held high through DONE -> second op accepted with no idle gap, tag_out tracks each tag; rst low on cycle 5 -> all outputs 0 with no done.
